// File: rtl/reg_rr_arbiter.sv
// reg_rr_arbiter: round-robin arbiter sharing one register-interface slave
// port among NumMasters masters. The grant is held for a whole transaction,
// and priority rotates starting just after the last completed grant.
// Optional feature: define REG_RR_ARBITER_TIMEOUT_EN to abort BUSY
// transactions after TimeoutCycles cycles with an error response.
module reg_rr_arbiter #(
    parameter int NumMasters    = 2,
    parameter int AddrWidth     = 64,
    parameter int DataWidth     = 32,
    parameter int TimeoutCycles = 256
) (
    input  logic                                       clk_i,
    input  logic                                       rst_ni,
    input  logic [NumMasters-1:0]                      mst_valid_i,
    input  logic [NumMasters-1:0]                      mst_write_i,
    input  logic [NumMasters-1:0][AddrWidth-1:0]       mst_addr_i,
    input  logic [NumMasters-1:0][DataWidth-1:0]       mst_wdata_i,
    input  logic [NumMasters-1:0][DataWidth/8-1:0]     mst_wstrb_i,
    output logic [NumMasters-1:0][DataWidth-1:0]       mst_rdata_o,
    output logic [NumMasters-1:0]                      mst_error_o,
    output logic [NumMasters-1:0]                      mst_ready_o,
    output logic                                       slv_valid_o,
    output logic                                       slv_write_o,
    output logic [AddrWidth-1:0]                       slv_addr_o,
    output logic [DataWidth-1:0]                       slv_wdata_o,
    output logic [DataWidth/8-1:0]                     slv_wstrb_o,
    input  logic [DataWidth-1:0]                       slv_rdata_i,
    input  logic                                       slv_error_i,
    input  logic                                       slv_ready_i,
    output logic                                       busy_o,
    output logic [$clog2(NumMasters)-1:0]              grant_o,
    output logic                                       timeout_o
);

    localparam int GW = $clog2(NumMasters);
    localparam logic [GW-1:0] LastIdx = GW'(NumMasters - 1);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e          state_q;
    logic [GW-1:0]   grant_q;
    logic [GW-1:0]   last_grant_q;
    logic [GW-1:0]   pick;
    logic [GW-1:0]   cand;
    logic            found;
    logic            busy;
    logic            gnt_valid;
    logic            done;
    logic            tmo;

    assign busy      = (state_q == BUSY);
    assign gnt_valid = mst_valid_i[grant_q];

    // Round-robin pick: first requester searching upward from last_grant+1, wrapping
    always_comb begin
        pick  = '0;
        found = 1'b0;
        cand  = (last_grant_q == LastIdx) ? '0 : last_grant_q + 1'b1;
        for (int j = 0; j < NumMasters; j++) begin
            if (!found && mst_valid_i[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
            cand = (cand == LastIdx) ? '0 : cand + 1'b1;
        end
    end

`ifdef REG_RR_ARBITER_TIMEOUT_EN
    localparam int CW = $clog2(TimeoutCycles);
    logic [CW-1:0] tmo_cnt_q;

    // Abort only a live request whose slave has not answered; slave ready wins a tie
    assign tmo = busy & gnt_valid & ~slv_ready_i & (tmo_cnt_q == CW'(TimeoutCycles - 1));

    // Count BUSY cycles without completion; held at zero while IDLE so BUSY starts fresh
    always_ff @(posedge clk_i) begin
        if (!rst_ni)            tmo_cnt_q <= '0;
        else if (!busy)         tmo_cnt_q <= '0;
        else if (!(done | tmo)) tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
`else
    assign tmo = 1'b0;
`endif

    assign slv_valid_o = busy & gnt_valid & ~tmo;
    assign slv_write_o = busy & mst_write_i[grant_q];
    assign slv_addr_o  = busy ? mst_addr_i[grant_q]  : '0;
    assign slv_wdata_o = busy ? mst_wdata_i[grant_q] : '0;
    assign slv_wstrb_o = busy ? mst_wstrb_i[grant_q] : '0;
    assign done        = slv_valid_o & slv_ready_i;
    assign busy_o      = busy;
    assign grant_o     = grant_q;
    assign timeout_o   = tmo;

    // Response steering: only the granted master sees the slave response
    for (genvar g = 0; g < NumMasters; g++) begin : g_mst
        logic sel;
        assign sel            = busy & (grant_q == GW'(g));
        assign mst_ready_o[g] = sel & (done | tmo);
        assign mst_error_o[g] = sel & (tmo | slv_error_i);
        assign mst_rdata_o[g] = (sel & ~tmo) ? slv_rdata_i : '0;
    end

    // Two-state FSM: arbitrate in IDLE, hold the grant through BUSY
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= LastIdx;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|mst_valid_i) begin
                        grant_q <= pick;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (done | tmo) begin
                        last_grant_q <= grant_q;
                        state_q      <= IDLE;
                    end else if (!gnt_valid) begin
                        // Master withdrew its request: drop it silently, priority unchanged
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
